// File: rtl/axis_multi_timer.sv
// axis_multi_timer: shared beat prescaler feeding CHANNELS independent
// down-counters, each one-shot or auto-reload, with a registered expiry pulse.
// Optional macro AXIS_MULTI_TIMER_STICKY_EN adds a per-channel sticky expiry
// flag cleared by exp_clear; without it exp_sticky is tied low.
//
// Stream handshake: a beat is accepted on any rising edge where
// s_axis_tvalid=1 and s_axis_tready=1; tready is constantly 1, so every
// tvalid cycle is an accepted beat and there is no backpressure.
module axis_multi_timer #(
  parameter int CNTR_WIDTH     = 64,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [CHANNELS-1:0]            run_flag,
  input  logic [CHANNELS-1:0]            cfg_flag,
  input  logic [CHANNELS*CNTR_WIDTH-1:0] cfg_data,
  input  logic [CHANNELS-1:0]            cfg_mode,
  input  logic [PRESCALE_WIDTH-1:0]      cfg_prescale,
  input  logic [CHANNELS-1:0]            exp_clear,
  output logic [CHANNELS-1:0]            trg_flag,
  output logic [CHANNELS-1:0]            exp_pulse,
  output logic [CHANNELS-1:0]            exp_sticky,
  output logic [CHANNELS*CNTR_WIDTH-1:0] sts_data,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tvalid
);

  localparam logic [CNTR_WIDTH-1:0] CNTR_ONE = CNTR_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] presc_reg;
  logic                      any_run;
  logic                      tick;

  assign s_axis_tready = 1'b1;

  // Tick is combinational so a channel reacts on the same edge as the beat;
  // the >= compare keeps a lowered cfg_prescale from letting presc_reg wrap.
  always_comb begin
    any_run = |run_flag;
    tick    = any_run & s_axis_tvalid & (presc_reg >= cfg_prescale);
  end

  // Shared prescaler: idle at 0 while nothing runs, else count accepted beats.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      presc_reg <= '0;
    end else if (!any_run) begin
      presc_reg <= '0;
    end else if (s_axis_tvalid) begin
      if (tick) presc_reg <= '0;
      else      presc_reg <= presc_reg + 1'b1;
    end
  end

`ifndef AXIS_MULTI_TIMER_STICKY_EN
  // exp_clear only matters when the sticky flags exist.
  logic unused_exp_clear;
  assign unused_exp_clear = ^exp_clear;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNTR_WIDTH-1:0] cntr_q;
    logic [CNTR_WIDTH-1:0] reload_q;
    logic                  mode_q;
    logic                  pulse_q;
    logic [CNTR_WIDTH-1:0] load_val;

    assign load_val = cfg_data[i*CNTR_WIDTH +: CNTR_WIDTH];

    // Channel counter: load beats tick; expiry on the 1->next transition
    // raises the pulse on the same edge the counter takes its new value.
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        cntr_q   <= '0;
        reload_q <= '0;
        mode_q   <= 1'b0;
        pulse_q  <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (cfg_flag[i]) begin
          cntr_q   <= load_val;
          reload_q <= load_val;
          mode_q   <= cfg_mode[i];
        end else if (tick && run_flag[i]) begin
          if (cntr_q > CNTR_ONE) begin
            cntr_q <= cntr_q - CNTR_ONE;
          end else if (cntr_q == CNTR_ONE) begin
            pulse_q <= 1'b1;
            cntr_q  <= mode_q ? reload_q : '0;
          end
        end
      end
    end

    assign sts_data[i*CNTR_WIDTH +: CNTR_WIDTH] = cntr_q;
    assign exp_pulse[i] = pulse_q;
    assign trg_flag[i]  = run_flag[i] & (cntr_q != '0);

`ifdef AXIS_MULTI_TIMER_STICKY_EN
    logic sticky_q;

    // Sticky flag follows the visible pulse; a set beats a same-cycle clear.
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) sticky_q <= 1'b0;
      else        sticky_q <= pulse_q | (sticky_q & ~exp_clear[i]);
    end

    assign exp_sticky[i] = sticky_q;
`else
    assign exp_sticky[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_axis_multi_timer.sv
// Bench for axis_multi_timer: directed scenarios plus a randomized run, all
// checked against a behavioural timer model kept in this file.
module tb_axis_multi_timer;

  localparam int W  = 64;
  localparam int CH = 4;
  localparam int PW = 16;
  localparam int OW = CH*W + 3*CH;

  // ---------------- clock / reset / DUT ----------------
  logic            aclk = 1'b0;
  logic            areset;
  logic [CH-1:0]   run_flag, cfg_flag, cfg_mode, exp_clear;
  logic [CH*W-1:0] cfg_data;
  logic [PW-1:0]   cfg_prescale;
  logic            s_axis_tvalid;
  logic [CH-1:0]   trg_flag, exp_pulse, exp_sticky;
  logic [CH*W-1:0] sts_data;
  logic            s_axis_tready;

  always #5 aclk = ~aclk;

  axis_multi_timer #(.CNTR_WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
    .aclk(aclk), .areset(areset), .run_flag(run_flag), .cfg_flag(cfg_flag),
    .cfg_data(cfg_data), .cfg_mode(cfg_mode), .cfg_prescale(cfg_prescale),
    .exp_clear(exp_clear), .trg_flag(trg_flag), .exp_pulse(exp_pulse),
    .exp_sticky(exp_sticky), .sts_data(sts_data), .s_axis_tready(s_axis_tready),
    .s_axis_tvalid(s_axis_tvalid)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  // Each channel is a count of remaining ticks; the prescaler is a beat count.
  logic [W-1:0]  m_cntr   [CH];
  logic [W-1:0]  m_reload [CH];
  logic          m_mode   [CH];
  int unsigned   m_beats;
  logic [CH-1:0] m_pulse, m_sticky;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cntr[c] = '0; m_reload[c] = '0; m_mode[c] = 1'b0;
    end
    m_beats = 0; m_pulse = '0; m_sticky = '0;
  endfunction

  function automatic void model_step();
    bit tick = 0;
    logic [CH-1:0] nxt_sticky = '0;
    if (run_flag == '0) m_beats = 0;
    else if (s_axis_tvalid) begin
      if (m_beats >= int'(cfg_prescale)) begin tick = 1; m_beats = 0; end
      else m_beats = m_beats + 1;
    end
`ifdef AXIS_MULTI_TIMER_STICKY_EN
    nxt_sticky = m_pulse | (m_sticky & ~exp_clear);
`endif
    m_pulse = '0;
    for (int c = 0; c < CH; c++) begin
      if (cfg_flag[c]) begin
        m_cntr[c]   = cfg_data[c*W +: W];
        m_reload[c] = cfg_data[c*W +: W];
        m_mode[c]   = cfg_mode[c];
      end else if (tick && run_flag[c] && m_cntr[c] != 0) begin
        if (m_cntr[c] == 1) begin
          m_pulse[c] = 1'b1;
          m_cntr[c]  = m_mode[c] ? m_reload[c] : '0;
        end else begin
          m_cntr[c] = m_cntr[c] - 1;
        end
      end
    end
    m_sticky = nxt_sticky;
  endfunction

  function automatic logic [OW-1:0] model_obs();
    logic [CH*W-1:0] s;
    logic [CH-1:0]   t;
    for (int c = 0; c < CH; c++) begin
      s[c*W +: W] = m_cntr[c];
      t[c] = run_flag[c] && (m_cntr[c] != 0);
    end
    return {s, m_pulse, t, m_sticky};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    run_flag = '0; cfg_flag = '0; cfg_mode = '0; exp_clear = '0;
    cfg_data = '0; cfg_prescale = '0; s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset = 1'b1;
    model_reset();
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  // Advance model and DUT by one clock; outputs are settled on return.
  task automatic step();
    model_step();
    @(posedge aclk); #1;
  endtask

  task automatic load(input int c, input logic [W-1:0] v, input logic mode);
    cfg_flag[c] = 1'b1;
    cfg_data[c*W +: W] = v;
    cfg_mode[c] = mode;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    areset = 1'b1;
    #2;
    vectors++;
    if ({sts_data, exp_pulse, trg_flag, exp_sticky} !== '0) begin
      miscompares++;
      $display("FAIL reset_during got=%h want=0", {sts_data, exp_pulse, trg_flag, exp_sticky});
    end
    vectors++;
    if (s_axis_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL tready got=%b want=1", s_axis_tready);
    end
    do_reset();
    run_flag = '1; s_axis_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({sts_data, exp_pulse, trg_flag, exp_sticky} !== '0) begin
        miscompares++;
        $display("FAIL reset_release k=%0d got=%h want=0", k, {sts_data, exp_pulse, trg_flag, exp_sticky});
      end
    end
  endtask

  task automatic test_oneshot();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    logic         pulse_q[$];
    logic         exp_p;
    do_reset();
    exp_q   = '{3, 2, 1, 0, 0, 0};
    pulse_q = '{0, 0, 0, 1, 0, 0};
    load(0, 3, 1'b0);
    run_flag = 4'b0001; s_axis_tvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      cfg_flag = '0;
      exp_v = exp_q.pop_front();
      exp_p = pulse_q.pop_front();
      vectors++;
      if (sts_data[W-1:0] !== exp_v || exp_pulse[0] !== exp_p || trg_flag[0] !== (exp_v != 0)) begin
        miscompares++;
        $display("FAIL oneshot k=%0d sts=%0d pulse=%b trg=%b want sts=%0d pulse=%b trg=%b",
                 k, sts_data[W-1:0], exp_pulse[0], trg_flag[0], exp_v, exp_p, exp_v != 0);
      end
    end
  endtask

  task automatic test_autoreload();
    logic [W-1:0] exp_q[$];
    logic         pulse_q[$];
    logic [W-1:0] exp_v;
    logic         exp_p;
    do_reset();
    load(1, 2, 1'b1);
    cfg_prescale = 2;
    step();
    cfg_flag = '0;
    run_flag = 4'b0010; s_axis_tvalid = 1'b1;
    // Beat k: ticks so far = k/3; value alternates 2,1; a pulse every 6 beats.
    for (int k = 1; k <= 24; k++) begin
      exp_q.push_back(((k/3) % 2 == 0) ? W'(2) : W'(1));
      pulse_q.push_back(k % 6 == 0);
    end
    while (exp_q.size() > 0) begin
      step();
      exp_v = exp_q.pop_front();
      exp_p = pulse_q.pop_front();
      vectors++;
      if (sts_data[W +: W] !== exp_v || exp_pulse[1] !== exp_p) begin
        miscompares++;
        $display("FAIL autoreload sts=%0d pulse=%b want sts=%0d pulse=%b",
                 sts_data[W +: W], exp_pulse[1], exp_v, exp_p);
      end
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    load(0, 1, 1'b0);
    run_flag = 4'b0001;
    step();
    load(0, 5, 1'b0);
    s_axis_tvalid = 1'b1;
    step();
    vectors++;
    if (sts_data[W-1:0] !== W'(5) || exp_pulse !== '0) begin
      miscompares++;
      $display("FAIL load_priority sts=%0d pulse=%b want sts=5 pulse=0", sts_data[W-1:0], exp_pulse);
    end
    cfg_flag = '0;
    step();
    vectors++;
    if ({sts_data, exp_pulse, trg_flag, exp_sticky} !== model_obs()) begin
      miscompares++;
      $display("FAIL load_after got=%h want=%h", {sts_data, exp_pulse, trg_flag, exp_sticky}, model_obs());
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    load(2, 9, 1'b1);
    run_flag = 4'b0100; s_axis_tvalid = 1'b1;
    step();
    cfg_flag = '0;
    for (int k = 0; k < 5; k++) step();
    #2 areset = 1'b1;
    #1;
    model_reset();
    vectors++;
    if ({sts_data, exp_pulse, trg_flag, exp_sticky} !== '0) begin
      miscompares++;
      $display("FAIL reset_async got=%h want=0", {sts_data, exp_pulse, trg_flag, exp_sticky});
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      vectors++;
      if ({sts_data, exp_pulse, trg_flag, exp_sticky} !== '0) begin
        miscompares++;
        $display("FAIL reset_discard k=%0d got=%h want=0", k, {sts_data, exp_pulse, trg_flag, exp_sticky});
      end
    end
  endtask

  task automatic test_run_gate();
    do_reset();
    load(0, 1, 1'b0);
    load(3, 2, 1'b0);
    step();
    cfg_flag = '0;
    run_flag = 4'b0001; s_axis_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (exp_pulse[0] !== (k == 0) || sts_data[3*W +: W] !== W'(2) || exp_pulse[3] !== 1'b0) begin
        miscompares++;
        $display("FAIL run_gate_hold k=%0d p0=%b ch3=%0d p3=%b want p0=%b ch3=2 p3=0",
                 k, exp_pulse[0], sts_data[3*W +: W], exp_pulse[3], k == 0);
      end
    end
    run_flag = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (exp_pulse[3] !== (k == 1) || sts_data[3*W +: W] !== W'(k == 0 ? 1 : 0)) begin
        miscompares++;
        $display("FAIL run_gate_resume k=%0d p3=%b ch3=%0d want p3=%b ch3=%0d",
                 k, exp_pulse[3], sts_data[3*W +: W], k == 1, k == 0 ? 1 : 0);
      end
    end
  endtask

  task automatic test_sticky();
    do_reset();
    load(1, 1, 1'b0);
    step();
    cfg_flag = '0;
    run_flag = 4'b0010; s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    step();
    load(1, 1, 1'b0);
    step();
    cfg_flag = '0; s_axis_tvalid = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    exp_clear = 4'b0010;
    step();
    vectors++;
    if ({sts_data, exp_pulse, trg_flag, exp_sticky} !== model_obs()) begin
      miscompares++;
      $display("FAIL sticky_model got=%h want=%h", {sts_data, exp_pulse, trg_flag, exp_sticky}, model_obs());
    end
`ifdef AXIS_MULTI_TIMER_STICKY_EN
    vectors++;
    if (exp_sticky[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL sticky_set_wins got=%b want=1", exp_sticky[1]);
    end
`endif
    step();
    vectors++;
    if (exp_sticky !== 4'b0000) begin
      miscompares++;
      $display("FAIL sticky_clear got=%b want=0000", exp_sticky);
    end
    exp_clear = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < CH; c++) begin
        cfg_flag[c] = ($urandom_range(0, 9) == 0);
        cfg_mode[c] = $urandom_range(0, 1);
        if ($urandom_range(0, 15) == 0) cfg_data[c*W +: W] = {$urandom, $urandom};
        else cfg_data[c*W +: W] = W'($urandom_range(0, 6));
        run_flag[c] = ($urandom_range(0, 4) != 0);
      end
      if ($urandom_range(0, 7) == 0) run_flag = '0;
      if ($urandom_range(0, 19) == 0) cfg_prescale = PW'($urandom_range(0, 3));
      s_axis_tvalid = ($urandom_range(0, 9) < 7);
      exp_clear = CH'($urandom_range(0, 15));
      step();
      vectors++;
      if ({sts_data, exp_pulse, trg_flag, exp_sticky} !== model_obs()) begin
        miscompares++;
        $display("FAIL random k=%0d got=%h want=%h", k, {sts_data, exp_pulse, trg_flag, exp_sticky}, model_obs());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    areset = 1'b0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_load_priority();
    test_reset_midcount();
    test_run_gate();
    test_sticky();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
